// File: rtl/apb4_master.sv
// apb4_master: APB4 initiator bridging a valid/ready request/response port onto an APB4 bus.
// One transfer is outstanding at a time. An optional wait-state timeout aborts transfers to
// a slave that never raises pready_i.
//
// Ports:
//   clk_i, rst_i                 clock (also pclk) and synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake; ready only while idle
//   req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i   request payload
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_rdata_o, rsp_err_o, rsp_timeout_o   response payload
//   busy_o                       transfer or response in progress
//   paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o   APB outputs
//   pready_i, prdata_i, pslverr_i                                      APB inputs
module apb4_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic                    busy_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    // Keep at least one bit so TIMEOUT=0 still elaborates.
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]            state_q,       state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [2:0]            pprot_q,       pprot_d;
    logic                  pwrite_q,      pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic [STRB_W-1:0]     pstrb_q,       pstrb_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_d;

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    paddr_d   = req_addr_i;
                    pprot_d   = req_prot_i;
                    pwrite_d  = req_write_i;
                    // Reads drive zero write data and strobes.
                    pwdata_d  = req_write_i ? req_wdata_i : '0;
                    pstrb_d   = req_write_i ? req_strb_i  : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    // A ready slave wins over a timeout expiring in the same cycle.
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (wait_cnt_q != CNT_MAX) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign paddr_o       = paddr_q;
    assign pprot_o       = pprot_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master.sv
// Testbench for apb4_master: directed transfers with a response scoreboard.
module tb_apb4_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_write_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_strb_i;
    logic [2:0]  req_prot_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        busy_o;
    logic [31:0] paddr_o;
    logic [2:0]  pprot_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    apb4_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_write_i  (req_write_i),
        .req_wdata_i  (req_wdata_i),
        .req_strb_i   (req_strb_i),
        .req_prot_i   (req_prot_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o       (busy_o),
        .paddr_o      (paddr_o),
        .pprot_o      (pprot_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .pwdata_o     (pwdata_o),
        .pstrb_o      (pstrb_o),
        .pready_i     (pready_i),
        .prdata_i     (prdata_i),
        .pslverr_i    (pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted response against the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
                chk("rsp_timeout", {31'd0, rsp_timeout_o}, {31'd0, e.to});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_rsp(input logic [31:0] rd, input logic err, input logic to);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        e.to    = to;
        exp_q.push_back(e);
    endtask

    task automatic setup_checks(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [3:0] s, input logic [2:0] p);
        chk("setup_psel", {31'd0, psel_o}, 32'd1);
        chk("setup_penable", {31'd0, penable_o}, 32'd0);
        chk("setup_paddr", paddr_o, a);
        chk("setup_pwrite", {31'd0, pwrite_o}, {31'd0, w});
        chk("setup_pwdata", pwdata_o, w ? d : 32'd0);
        chk("setup_pstrb", {28'd0, pstrb_o}, w ? {28'd0, s} : 32'd0);
        chk("setup_pprot", {29'd0, pprot_o}, {29'd0, p});
    endtask

    // Issue from IDLE; returns in the first ACCESS cycle.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_write_i = w;
        req_wdata_i = d;
        req_strb_i  = s;
        req_prot_i  = p;
        tick();
        req_valid_i = 1'b0;
        req_addr_i  = 32'hFFFF_FFFF;
        setup_checks(a, w, d, s, p);
        tick();
        chk("access_psel", {31'd0, psel_o}, 32'd1);
        chk("access_penable", {31'd0, penable_o}, 32'd1);
    endtask

    // From the first ACCESS cycle: insert wait states, then complete; returns in RESP.
    task automatic access(input int waits, input logic [31:0] rd, input logic err,
                          input logic [31:0] a);
        for (int i = 0; i < waits; i++) begin
            pready_i  = 1'b0;
            prdata_i  = 32'hDEAD_0000 + i;
            pslverr_i = 1'b1;
            chk("wait_penable", {31'd0, penable_o}, 32'd1);
            chk("wait_paddr", paddr_o, a);
            tick();
        end
        chk("last_penable", {31'd0, penable_o}, 32'd1);
        pready_i  = 1'b1;
        prdata_i  = rd;
        pslverr_i = err;
        tick();
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = 32'h0;
        chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("done_psel", {31'd0, psel_o}, 32'd0);
        chk("done_penable", {31'd0, penable_o}, 32'd0);
        chk("hold_paddr", paddr_o, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_wdata_i = '0;
        req_strb_i  = '0;
        req_prot_i  = '0;
        rsp_ready_i = 1'b1;
        pready_i    = 1'b0;
        prdata_i    = '0;
        pslverr_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_psel", {31'd0, psel_o}, 32'd0);
        chk("rst_penable", {31'd0, penable_o}, 32'd0);
        chk("rst_paddr", paddr_o, 32'd0);
        chk("rst_pwdata", pwdata_o, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst_rsp_timeout", {31'd0, rsp_timeout_o}, 32'd0);

        // Zero-wait write; prdata nonzero must not leak into the response.
        expect_rsp(32'h0, 1'b0, 1'b0);
        issue(32'h4, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000);
        access(0, 32'hFFFF_0000, 1'b0, 32'h4);
        tick();
        chk("idle_after_write", {31'd0, req_ready_o}, 32'd1);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        // Read with three wait states: penable held four cycles.
        expect_rsp(32'h1234_5678, 1'b0, 1'b0);
        issue(32'h8, 1'b0, 32'hAAAA_AAAA, 4'hF, 3'b010);
        access(3, 32'h1234_5678, 1'b0, 32'h8);
        tick();

        // Read with slave error: data still captured.
        expect_rsp(32'hCAFE_F00D, 1'b1, 1'b0);
        issue(32'hC, 1'b0, 32'h0, 4'h0, 3'b101);
        access(0, 32'hCAFE_F00D, 1'b1, 32'hC);
        tick();

        // Timeout: pready stuck low for exactly 16 ACCESS cycles.
        expect_rsp(32'h0, 1'b1, 1'b1);
        issue(32'h20, 1'b0, 32'h0, 4'h0, 3'b000);
        pready_i = 1'b0;
        prdata_i = 32'hFFFF_FFFF;
        n = 0;
        while (!rsp_valid_o && n < 100) begin
            if (penable_o) n++;
            tick();
        end
        prdata_i = 32'h0;
        chk("timeout_cycles", n, 32'd16);
        chk("timeout_psel", {31'd0, psel_o}, 32'd0);
        chk("timeout_penable", {31'd0, penable_o}, 32'd0);
        chk("timeout_flag", {31'd0, rsp_timeout_o}, 32'd1);
        tick();

        // Ready on the 16th ACCESS cycle wins over the timeout.
        expect_rsp(32'h0BAD_C0DE, 1'b0, 1'b0);
        issue(32'h24, 1'b0, 32'h0, 4'h0, 3'b000);
        access(15, 32'h0BAD_C0DE, 1'b0, 32'h24);
        tick();

        // Response back-pressure with a queued second request.
        rsp_ready_i = 1'b0;
        expect_rsp(32'h5555_AAAA, 1'b0, 1'b0);
        issue(32'h30, 1'b0, 32'h0, 4'h0, 3'b001);
        access(0, 32'h5555_AAAA, 1'b0, 32'h30);
        req_valid_i = 1'b1;
        req_addr_i  = 32'h34;
        req_write_i = 1'b1;
        req_wdata_i = 32'h1122_3344;
        req_strb_i  = 4'h3;
        req_prot_i  = 3'b010;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("stall_rdata", rsp_rdata_o, 32'h5555_AAAA);
            chk("stall_err", {31'd0, rsp_err_o}, 32'd0);
            chk("stall_req_ready", {31'd0, req_ready_o}, 32'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        chk("queued_req_ready", {31'd0, req_ready_o}, 32'd1);
        expect_rsp(32'h0, 1'b0, 1'b0);
        tick();
        req_valid_i = 1'b0;
        setup_checks(32'h34, 1'b1, 32'h1122_3344, 4'h3, 3'b010);
        tick();
        chk("queued_penable", {31'd0, penable_o}, 32'd1);
        access(0, 32'h7777_7777, 1'b0, 32'h34);
        tick();

        // Reset during ACCESS with wait states: no response for this transfer.
        issue(32'h40, 1'b0, 32'h0, 4'h0, 3'b000);
        pready_i = 1'b0;
        tick();
        tick();
        chk("pre_rst_penable", {31'd0, penable_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_psel", {31'd0, psel_o}, 32'd0);
        chk("mid_rst_penable", {31'd0, penable_o}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_paddr", paddr_o, 32'd0);
        repeat (4) tick();

        // Recovery transfer after reset.
        expect_rsp(32'h0, 1'b0, 1'b0);
        issue(32'h44, 1'b1, 32'h0102_0304, 4'h9, 3'b000);
        access(1, 32'h0, 1'b0, 32'h44);
        repeat (3) tick();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
